wdt_cfg_sequencer: RTL and testbench

Single-clock sequencer for the watchdog's configuration registers. It buffers register writes (WDEN, WDLIVE, WTOCNT) from the AXI slave side and forwards them one at a time over one shared CDC write channel. It sits between the WDT bus wrapper's write-decode logic and one handshake synchronizer, so the three per-register synchronizers are no longer needed. It provides write coalescing, fixed-priority ordering, a completion timeout and a sticky error flag.

---
 rtl/wdt_cfg_sequencer.sv | 156 +++++++++++++++
 tb/tb_wdt_cfg_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_cfg_sequencer.sv
// Watchdog config-register write sequencer: three coalescing slots forwarded one at a time
// over a shared CDC channel. Optional macro WDT_SEQ_LOCK_EN adds a WDEN disable lock.
module wdt_cfg_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [1:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ch_req,
  output logic [1:0]        ch_sel,
  output logic [DATA_W-1:0] ch_data,
  input  logic              ch_ready,
  output logic [2:0]        pend,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_slot [3];
  logic [2:0]        r_pend;
  logic [15:0]       r_cnt;
  logic              r_ch_req;
  logic [1:0]        r_ch_sel;
  logic [DATA_W-1:0] r_ch_data;
  logic              r_busy;
  logic              r_err;

  logic              w_lock_drop;
  logic              w_wr_slot;
  logic              w_wr_bad;
  logic [2:0]        w_wr_oh;
  logic [2:0]        w_gnt_oh;
  logic [1:0]        w_gnt_sel;
  logic [15:0]       w_cnt_nxt;
  logic              w_tmo;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef WDT_SEQ_LOCK_EN
  logic r_lock;
  assign w_lock_drop = r_lock && (wr_sel == 2'd0) && (wr_data == '0);
`else
  assign w_lock_drop = 1'b0;
`endif

  assign w_wr_slot = wr_valid && (wr_sel != 2'd3) && !w_lock_drop;
  assign w_wr_bad  = wr_valid && ((wr_sel == 2'd3) || w_lock_drop);
  assign w_cnt_nxt = sat_inc(r_cnt);
  // Ready in the same cycle as the limit counts as success
  assign w_tmo     = (r_state == S_WAIT) && !ch_ready && (w_cnt_nxt == TMO);

  always_comb begin
    w_wr_oh = 3'b000;
    if (w_wr_slot) begin
      case (wr_sel)
        2'd0:    w_wr_oh = 3'b001;
        2'd1:    w_wr_oh = 3'b010;
        2'd2:    w_wr_oh = 3'b100;
        default: w_wr_oh = 3'b000;
      endcase
    end
  end

  // Count before enable: WTOCNT > WDEN > WDLIVE
  always_comb begin
    w_gnt_oh  = 3'b000;
    w_gnt_sel = 2'd0;
    if (r_pend[2]) begin
      w_gnt_oh  = 3'b100;
      w_gnt_sel = 2'd2;
    end else if (r_pend[0]) begin
      w_gnt_oh  = 3'b001;
      w_gnt_sel = 2'd0;
    end else if (r_pend[1]) begin
      w_gnt_oh  = 3'b010;
      w_gnt_sel = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pend    <= 3'b000;
      r_cnt     <= 16'd0;
      r_ch_req  <= 1'b0;
      r_ch_sel  <= 2'd0;
      r_ch_data <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      for (int i = 0; i < 3; i++) r_slot[i] <= '0;
`ifdef WDT_SEQ_LOCK_EN
      r_lock    <= 1'b0;
`endif
    end else begin
      if (w_wr_bad || w_tmo)
        r_err <= 1'b1;
      else if (err_clr)
        r_err <= 1'b0;

      for (int i = 0; i < 3; i++)
        if (w_wr_oh[i]) r_slot[i] <= wr_data;

      // A write landing on the slot being granted keeps it pending
      r_pend <= (r_pend & ~((r_state == S_IDLE) ? w_gnt_oh : 3'b000)) | w_wr_oh;

      case (r_state)
        S_IDLE: begin
          if (|r_pend) begin
            r_ch_sel  <= w_gnt_sel;
            r_ch_data <= r_slot[w_gnt_sel];
            r_ch_req  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          r_ch_req <= 1'b0;
          r_cnt    <= 16'd0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (ch_ready) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
`ifdef WDT_SEQ_LOCK_EN
            if ((r_ch_sel == 2'd0) && (r_ch_data != '0)) r_lock <= 1'b1;
`endif
          end else if (w_cnt_nxt == TMO) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_req  = r_ch_req;
  assign ch_sel  = r_ch_sel;
  assign ch_data = r_ch_data;
  assign pend    = r_pend;
  assign busy    = r_busy;
  assign err     = r_err;

endmodule

// File: tb/tb_wdt_cfg_sequencer.sv
// Directed bench for wdt_cfg_sequencer: per-cycle vector table plus hand sequences
// for timeout, priority, coalescing, lock and asynchronous reset.
module tb_wdt_cfg_sequencer;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic [1:0]    wr_sel = 2'd0;
  logic [DW-1:0] wr_data = '0;
  logic          ch_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic          ch_req;
  logic [1:0]    ch_sel;
  logic [DW-1:0] ch_data;
  logic [2:0]    pend;
  logic          busy;
  logic          err;

  int n_chk  = 0;
  int n_fail = 0;

  wdt_cfg_sequencer #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data),
    .ch_req(ch_req), .ch_sel(ch_sel), .ch_data(ch_data), .ch_ready(ch_ready),
    .pend(pend), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [1:0]    s;
    logic [DW-1:0] d;
    logic          rdy;
    logic          clr;
    logic          req;
    logic [1:0]    csel;
    logic [DW-1:0] cdat;
    logic [2:0]    pnd;
    logic          bsy;
    logic          er;
  } vec_t;

  vec_t tv [23];

  function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [DW-1:0] d,
                              input logic rdy, input logic clr, input logic req,
                              input logic [1:0] csel, input logic [DW-1:0] cdat,
                              input logic [2:0] pnd, input logic bsy, input logic er);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.rdy = rdy; r.clr = clr;
    r.req = req; r.csel = csel; r.cdat = cdat; r.pnd = pnd; r.bsy = bsy; r.er = er;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_sel   = s;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    wr_sel   = 2'd0;
    wr_data  = '0;
  endtask

  task automatic get_req(input string nm, input logic [1:0] es, input logic [DW-1:0] ed);
    int k = 0;
    while (!ch_req && k < 50) begin
      tick();
      k++;
    end
    chk({nm, "_req"}, 64'(ch_req), 64'd1);
    chk({nm, "_sel_data"}, 64'({ch_sel, ch_data}), 64'({es, ed}));
  endtask

  task automatic respond(input int dly);
    repeat (dly) tick();
    ch_ready = 1'b1;
    tick();
    ch_ready = 1'b0;
  endtask

  task automatic no_req(input string nm, input int n);
    int seen = 0;
    repeat (n) begin
      tick();
      if (ch_req) seen++;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    //           v  s  d        rdy clr | req sel data     pend busy err
    tv[0]  = mk(1, 2, 'h100,   0, 0,    0, 0, 'h0,     3'd4, 0, 0);
    tv[1]  = mk(0, 0, 'h0,     0, 0,    1, 2, 'h100,   3'd0, 1, 0);
    tv[2]  = mk(0, 0, 'h0,     0, 0,    0, 2, 'h100,   3'd0, 1, 0);
    tv[3]  = mk(0, 0, 'h0,     0, 0,    0, 2, 'h100,   3'd0, 1, 0);
    tv[4]  = mk(0, 0, 'h0,     0, 0,    0, 2, 'h100,   3'd0, 1, 0);
    tv[5]  = mk(0, 0, 'h0,     1, 0,    0, 2, 'h100,   3'd0, 0, 0);
    tv[6]  = mk(0, 0, 'h0,     0, 0,    0, 2, 'h100,   3'd0, 0, 0);
    tv[7]  = mk(0, 0, 'h0,     1, 0,    0, 2, 'h100,   3'd0, 0, 0);
    tv[8]  = mk(1, 0, 'h5,     0, 0,    0, 2, 'h100,   3'd1, 0, 0);
    tv[9]  = mk(1, 0, 'h6,     0, 0,    1, 0, 'h5,     3'd1, 1, 0);
    tv[10] = mk(0, 0, 'h0,     0, 0,    0, 0, 'h5,     3'd1, 1, 0);
    tv[11] = mk(0, 0, 'h0,     1, 0,    0, 0, 'h5,     3'd1, 0, 0);
    tv[12] = mk(0, 0, 'h0,     0, 0,    1, 0, 'h6,     3'd0, 1, 0);
    tv[13] = mk(0, 0, 'h0,     0, 0,    0, 0, 'h6,     3'd0, 1, 0);
    tv[14] = mk(1, 0, 'h7,     0, 0,    0, 0, 'h6,     3'd1, 1, 0);
    tv[15] = mk(0, 0, 'h0,     1, 0,    0, 0, 'h6,     3'd1, 0, 0);
    tv[16] = mk(0, 0, 'h0,     0, 0,    1, 0, 'h7,     3'd0, 1, 0);
    tv[17] = mk(0, 0, 'h0,     0, 0,    0, 0, 'h7,     3'd0, 1, 0);
    tv[18] = mk(0, 0, 'h0,     1, 0,    0, 0, 'h7,     3'd0, 0, 0);
    tv[19] = mk(1, 3, 'hdead,  0, 0,    0, 0, 'h7,     3'd0, 0, 1);
    tv[20] = mk(0, 0, 'h0,     0, 1,    0, 0, 'h7,     3'd0, 0, 0);
    tv[21] = mk(1, 3, 'h1,     0, 1,    0, 0, 'h7,     3'd0, 0, 1);
    tv[22] = mk(0, 0, 'h0,     0, 1,    0, 0, 'h7,     3'd0, 0, 0);

    repeat (3) tick();
    chk("reset_state", 64'({ch_req, ch_sel, ch_data, pend, busy, err}), 64'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 23; i++) begin
      wr_valid = tv[i].v;
      wr_sel   = tv[i].s;
      wr_data  = tv[i].d;
      ch_ready = tv[i].rdy;
      err_clr  = tv[i].clr;
      tick();
      chk($sformatf("vec%0d", i), 64'({ch_req, ch_sel, ch_data, pend, busy, err}),
          64'({tv[i].req, tv[i].csel, tv[i].cdat, tv[i].pnd, tv[i].bsy, tv[i].er}));
    end
    wr_valid = 1'b0; wr_sel = 2'd0; wr_data = '0; ch_ready = 1'b0; err_clr = 1'b0;

    // Timeout: no ready, err appears TMO+1 cycles after the request cycle
    wr(2'd1, 'h3);
    tick();
    chk("tmo_req", 64'(ch_req), 64'd1);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      chk($sformatf("tmo_wait%0d", k), 64'({busy, err}), 64'(2'b10));
    end
    tick();
    chk("tmo_err", 64'({busy, err, pend, ch_req}), 64'({1'b0, 1'b1, 3'b000, 1'b0}));
    no_req("tmo_noretry", 6);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_errclr", 64'(err), 64'd0);

    // Ready in the same cycle the limit is reached is a success
    wr(2'd1, 'h4);
    tick();
    chk("edge_req", 64'(ch_req), 64'd1);
    repeat (TMO) tick();
    ch_ready = 1'b1;
    tick();
    ch_ready = 1'b0;
    chk("edge_ok", 64'({busy, err}), 64'd0);

    // Priority: writes queued during a transfer drain as WTOCNT, WDEN, WDLIVE
    wr(2'd1, 'h9);
    tick();
    get_req("pri0", 2'd1, 'h9);
    wr(2'd1, 'h1);
    wr(2'd0, 'h1);
    wr(2'd2, 'h50);
    chk("pri_pend", 64'(pend), 64'd7);
    respond(0);
    get_req("pri1", 2'd2, 'h50);
    respond(2);
    get_req("pri2", 2'd0, 'h1);
    respond(2);
    get_req("pri3", 2'd1, 'h1);
    respond(2);
    no_req("pri_end", 10);

    // Coalescing: two WDLIVE writes while busy give one transfer with the last value
    wr(2'd2, 'h33);
    tick();
    get_req("coal0", 2'd2, 'h33);
    wr(2'd1, 'h1);
    wr(2'd1, 'h0);
    respond(0);
    get_req("coal1", 2'd1, 'h0);
    respond(2);
    no_req("coal_end", 10);
    chk("coal_pend", 64'(pend), 64'd0);

`ifdef WDT_SEQ_LOCK_EN
    wr(2'd0, 'h0);
    chk("lock_drop", 64'({err, pend}), 64'({1'b1, 3'b000}));
    no_req("lock_noreq", 10);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("lock_errclr", 64'(err), 64'd0);
`else
    wr(2'd0, 'h0);
    get_req("nolock", 2'd0, 'h0);
    chk("nolock_err", 64'(err), 64'd0);
    respond(2);
`endif

    // Asynchronous reset in the request cycle with another slot pending
    wr(2'd2, 'h77);
    wr(2'd1, 'h5);
    get_req("rst0", 2'd2, 'h77);
    chk("rst0_pend", 64'(pend), 64'd2);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async", 64'({ch_req, ch_sel, ch_data, pend, busy, err}), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_idle", 64'({ch_req, ch_sel, ch_data, pend, busy, err}), 64'd0);
    no_req("rst_noreq", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
